// File: rtl/tt_um_kvosic_count_checker.sv
// Count-stream checker: verifies each sample is the previous sample + 1 (mod 16), acquires and holds lock.
// Latency: a sample taken at a rising edge is reflected on every output right after that same edge.
// Backpressure: none; samples are taken whenever ena & sample_en, and ena low freezes all state.
module tt_um_kvosic_count_checker #(
  parameter int LOCK_LEN = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] GOOD_LAST = 4'(LOCK_LEN - 1);

  state_t     state_q, state_d;
  logic [3:0] prev_q, prev_d;
  logic [3:0] good_cnt_q, good_cnt_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       err_sticky_q, err_sticky_d;
  logic       mismatch_q, mismatch_d;

  logic       smp;
  logic       clr;
  logic [3:0] v;
  logic [3:0] exp_val;
  logic       hit;

  // Unused tile inputs are folded together so they are visibly consumed.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, uio_in, ui_in[7:6]};

  assign smp     = ena & ui_in[4];
  assign clr     = ena & ui_in[5];
  assign v       = ui_in[3:0];
  assign exp_val = prev_q + 4'd1;
  assign hit     = (v == exp_val);

  // State register and datapath registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      prev_q       <= 4'd0;
      good_cnt_q   <= 4'd0;
      err_cnt_q    <= 8'd0;
      err_sticky_q <= 1'b0;
      mismatch_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      good_cnt_q   <= good_cnt_d;
      err_cnt_q    <= err_cnt_d;
      err_sticky_q <= err_sticky_d;
      mismatch_q   <= mismatch_d;
    end
  end

  // Next-state logic: sequence compare, lock acquisition and error bookkeeping.
  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    good_cnt_d   = good_cnt_q;
    err_cnt_d    = err_cnt_q;
    err_sticky_d = err_sticky_q;
    mismatch_d   = 1'b0;

    if (smp) begin
      prev_d = v;
      unique case (state_q)
        ST_IDLE: begin
          // First sample only seeds the reference; nothing to compare against yet.
          good_cnt_d = 4'd0;
          state_d    = ST_ACQ;
        end
        ST_ACQ: begin
          if (hit) begin
            if (good_cnt_q == GOOD_LAST) begin
              good_cnt_d = 4'd0;
              state_d    = ST_LOCKED;
            end else begin
              good_cnt_d = good_cnt_q + 4'd1;
            end
          end else begin
            // Misses while acquiring restart the run but are not counted as lock losses.
            good_cnt_d = 4'd0;
            mismatch_d = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (!hit) begin
            mismatch_d   = 1'b1;
            err_sticky_d = 1'b1;
            err_cnt_d    = (err_cnt_q == 8'hFF) ? 8'hFF : err_cnt_q + 8'd1;
            good_cnt_d   = 4'd0;
            state_d      = ST_ACQ;
          end
        end
        default: begin
          state_d    = ST_IDLE;
          good_cnt_d = 4'd0;
        end
      endcase
    end

    // Clear takes priority over a simultaneous lock loss.
    if (clr) begin
      err_cnt_d    = 8'd0;
      err_sticky_d = 1'b0;
    end
  end

  // Outputs are pure decodes of registers.
  assign uo_out  = {(state_q == ST_ACQ), mismatch_q, err_sticky_q, (state_q == ST_LOCKED), exp_val};
  assign uio_out = err_cnt_q;
  assign uio_oe  = 8'hFF;

endmodule

// File: doc/tt_um_kvosic_count_checker.md
# tt_um_kvosic_count_checker

Receive-side companion to the 4-bit free-running counter tile: samples a 4-bit count stream on `ui_in[3:0]`, checks that each sample equals the previous one plus 1 (mod 16), and acquires and holds lock on the sequence. It reports lock status, a mismatch pulse, a sticky error flag and a saturating error count. It sits on the TinyTapeout user-tile interface and is driven by the counter's `uo_out[3:0]`, either externally or in a shared testbench.

## Interface
- `LOCK_LEN`, default 4: consecutive correct increments needed to enter LOCKED; legal range 1..15.
- `clk`  in  1  tile clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `ena`  in  1  tile enable; when 0, sampling is suppressed and all state is held.
- `ui_in`  in  8  [3:0] observed count; [4] `sample_en`; [5] `err_clr`; [7:6] unused.
- `uo_out`  out  8  [3:0] expected next value; [4] `locked`; [5] `err_sticky`; [6] `mismatch` pulse; [7] `acquiring`.
- `uio_in`  in  8  unused.
- `uio_out`  out  8  `err_cnt`, the saturating count of lock losses.
- `uio_oe`  out  8  constant 8'hFF.

## Operation
- Effective sample: `smp = ena & ui_in[4]`. Value `v = ui_in[3:0]`. Registered previous sample `prev`. Expected value `exp = prev + 1` (4-bit, so 4'hF wraps to 4'h0).
- Registers:
  - `state`: IDLE, ACQ or LOCKED.
  - `prev[3:0]`.
  - `good_cnt[3:0]`.
  - `err_cnt[7:0]`.
  - `err_sticky`.
  - `mismatch`.
- IDLE, on `smp`:
  - `prev <= v`, `good_cnt <= 0`, go to ACQ.
  - No comparison is made.
- ACQ, on `smp`:
  - Always `prev <= v`.
  - If `v == exp`: when `good_cnt == LOCK_LEN-1`, go to LOCKED with `good_cnt <= 0`; otherwise `good_cnt++`.
  - Else: `good_cnt <= 0`, `mismatch` pulses, and the state stays ACQ.
  - `err_cnt` is not incremented in ACQ.
- LOCKED, on `smp`:
  - Always `prev <= v`.
  - If `v == exp`: stay in LOCKED.
  - Else:
    - `mismatch` pulses.
    - `err_sticky <= 1`.
    - `err_cnt <= (err_cnt == 8'hFF) ? 8'hFF : err_cnt + 1`.
    - Go to ACQ with `good_cnt <= 0`.
- No `smp`: `state`, `prev` and `good_cnt` hold; `mismatch <= 0`.
- `mismatch` is a registered one-cycle pulse. It is high in the cycle after a failing compare and is never held.
- `err_clr` (ui_in[5], gated by `ena`):
  - Clears `err_cnt` and `err_sticky`.
  - If it coincides with a LOCKED mismatch, clear wins: both end at 0.
  - It does not affect `state`, `prev`, `good_cnt` or `mismatch`.
- Output decode:
  - `uo_out[3:0] = prev + 1`; reads 4'h1 in IDLE after reset.
  - `uo_out[4] = (state == LOCKED)`.
  - `uo_out[7] = (state == ACQ)`.
- `ena` low: behaves as if `sample_en = 0` and `err_clr = 0` every cycle. Outputs keep their last values, except `mismatch`, which drops to 0.

## Timing
- Reset: when `rst_n` is low at a rising edge, after that edge:
  - `state` = IDLE; `prev`, `good_cnt` and `err_cnt` = 0; `err_sticky` and `mismatch` = 0.
  - `uo_out` = 8'h01, `uio_out` = 8'h00, `uio_oe` = 8'hFF.
- Reset asserted mid-operation overrides all other inputs in that cycle; no partial update.
- Every output is a registered value or a pure decode of registers. The effect of a sample at edge N is visible after edge N.
- Lock latency from reset release, with one sample every cycle starting at edge 0:
  - Edge 0 enters ACQ.
  - Edges 1..LOCK_LEN are correct compares.
  - `locked` is high after edge LOCK_LEN (edge 4 for the default).
- After a LOCKED mismatch, relock needs LOCK_LEN further correct samples. Their reference is the mismatching value itself; the old sequence is not restored.
- No combinational path from `ui_in` to any output.

## Test plan
- Reset, then ramp 0,1,2,… with `sample_en = 1` every cycle, LOCK_LEN = 4 -> `locked` rises after the 5th sample (value 4); `acquiring` is high for the 4 cycles before; `err_cnt` = 0; `uo_out[3:0]` tracks value+1.
- Locked ramp through 14, 15, 0, 1 -> no `mismatch`; `locked` stays 1 (wrap is legal).
- Locked at 6, then inject 9 -> `mismatch` high for exactly 1 cycle, `err_sticky` = 1, `err_cnt` = 1, `acquiring` = 1. Continuing 10, 11, 12, 13 -> relock after the 13.
- Preload `err_cnt` to 255 via 255 lock/mismatch cycles, then one more mismatch -> `err_cnt` stays 8'hFF. Assert `err_clr` in the same cycle as a further LOCKED mismatch -> `err_cnt` = 0, `err_sticky` = 0, `mismatch` still pulses.
- Locked at 3, drop `ena` for 5 cycles while `ui_in` shows garbage, restore with value 4 -> no `mismatch`; still locked; outputs frozen while `ena` = 0.
- Pull `rst_n` low for one edge while in ACQ with `good_cnt` = 2 -> `uo_out` = 8'h01, `uio_out` = 0, IDLE. The next sample starts a fresh acquisition.
